serial_tx_arbiter: RTL and testbench

// - Shares one 8N1 UART transmit line between two byte requesters (req0 = CPU MMIO, req1 = debug/monitor).
// - Round-robin arbitration, valid/ready byte handshake, internal baud-tick divider, frame sequencing on txd.
// - Sits between the IO bus serial registers and the board TX pin, in the serial IO device group.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_baud_tick.sv | 30 +++
 rtl/serial_tx_arbiter.sv | 114 +++++++++++
 tb/tb_serial_tx_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial TX arbiter: frame state encoding and divider width helper.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Bits needed for a counter that runs 0..div-1 (never narrower than 1).
    function automatic int div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-period counter: runs 0..DIV-1 while enabled, pulses bit_tick on the last count.
module serial_baud_tick
    import serial_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic clkin,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);
    localparam int CW = div_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign bit_tick = enable && !clear && (count == LAST);

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Two-requester round-robin 8N1 UART transmitter.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit after the data bits.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       txd,
    output logic       busy,
    output logic       grant_id
);
    localparam int DIV = CLK_FREQ / BAUD;

    tx_state_t  state;
    logic       last_grant;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       bit_tick;
    logic       idle;
    logic       winner;

    assign idle = (state == ST_IDLE);

    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) winner = ~last_grant;
        else if (req1_valid)          winner = 1'b1;
    end

    // Gated by rst so no handshake can complete while reset is held.
    assign req0_ready = rst && idle && req0_valid && !winner;
    assign req1_ready = rst && idle && req1_valid &&  winner;

    serial_baud_tick #(.DIV(DIV)) u_baud (
        .clkin    (clkin),
        .rst      (rst),
        .clear    (idle),
        .enable   (!idle),
        .bit_tick (bit_tick)
    );

    // shift rotates rather than zero-fills, so parity can be taken from it after the last data bit.
    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            txd        <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            shift      <= '0;
            bit_idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        shift      <= winner ? req1_data : req0_data;
                        grant_id   <= winner;
                        last_grant <= winner;
                        bit_idx    <= '0;
                        txd        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        txd   <= shift[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift <= {shift[0], shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                            txd   <= ^shift;
                            state <= ST_PARITY;
`else
                            txd   <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        txd   <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Self-checking bench for serial_tx_arbiter against a cycle-count frame model.
module tb_serial_tx_arbiter;
    localparam int DIV = 10;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clkin = 1'b0;
    logic       rst   = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       r0, r1, txd, busy, gid;

    always #5 clkin = ~clkin;

    serial_tx_arbiter #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clkin      (clkin),
        .rst        (rst),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_ready (r1),
        .txd        (txd),
        .busy       (busy),
        .grant_id   (gid)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: one frame described by its accept cycle and byte.
    bit         m_active = 0;
    int         m_acc    = 0;
    logic [7:0] m_data   = '0;
    logic       m_last   = 1'b1;
    logic       m_gid    = 1'b0;
    logic       acc0, acc1;
    int         gq[$];
    int         aq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b < NBITS - 1) return ^d;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_last   = 1'b1;
        m_gid    = 1'b0;
    endtask

    task automatic sample();
        bit   idle_m;
        logic e_txd, e_r0, e_r1;
        idle_m = !(m_active && cyc > m_acc && cyc <= m_acc + FRAME);
        e_txd  = idle_m ? 1'b1 : frame_bit(m_data, (cyc - m_acc - 1) / DIV);
        e_r0   = rst && idle_m && v0 && (!v1 || m_last);
        e_r1   = rst && idle_m && v1 && (!v0 || !m_last);
        check("txd", txd, e_txd);
        check("busy", busy, !idle_m);
        check("req0_ready", r0, e_r0);
        check("req1_ready", r1, e_r1);
        check("grant_id", gid, m_gid);
        if (m_active && cyc == m_acc + 1) gq.push_back(int'(gid));
        acc0 = r0 && v0;
        acc1 = r1 && v1;
        if (acc0 || acc1) aq.push_back(cyc);
        if (e_r0 || e_r1) begin
            m_active = 1;
            m_acc    = cyc;
            m_data   = e_r1 ? d1 : d0;
            m_last   = e_r1;
            m_gid    = e_r1;
        end
    endtask

    task automatic step();
        @(negedge clkin);
        sample();
        cyc++;
        @(posedge clkin);
        #1;
    endtask

    initial begin
        int nb;
        // Reset state
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Tie: both held, alternate starting with req0
        gq.delete();
        v0 = 1'b1; d0 = 8'h11;
        v1 = 1'b1; d1 = 8'h22;
        for (int i = 0; i < 4 * (FRAME + 1); i++) step();
        v0 = 1'b0; v1 = 1'b0;
        check("tie_cnt", gq.size(), 4);
        if (gq.size() >= 4) begin
            check("tie_g0", gq[0], 0);
            check("tie_g1", gq[1], 1);
            check("tie_g2", gq[2], 0);
            check("tie_g3", gq[3], 1);
        end
        for (int i = 0; i < FRAME + 5; i++) step();

        // Single byte on req0
        nb = 0;
        v0 = 1'b1; d0 = 8'hA5;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (acc0) v0 = 1'b0;
            if (busy) nb++;
        end
        check("a5_busy_len", nb, FRAME);

        // Back-to-back on req1
        aq.delete();
        v1 = 1'b1; d1 = 8'h00;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step();
            if (acc1) begin
                if (d1 == 8'h00) d1 = 8'hFF;
                else v1 = 1'b0;
            end
        end
        check("b2b_cnt", aq.size(), 2);
        if (aq.size() >= 2) check("b2b_gap", aq[1] - aq[0], FRAME + 1);

        // Reset in the middle of data bit 4
        v0 = 1'b1; d0 = 8'h3C;
        for (int i = 0; i < 4 * FRAME && !(m_active && cyc == m_acc + 1 + 5 * DIV + 3); i++) begin
            step();
            if (acc0) v0 = 1'b0;
        end
        check("mid_reached", cyc, m_acc + 1 + 5 * DIV + 3);
        #2;
        rst = 1'b0;
        v0  = 1'b0;
        model_reset();
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_gid", gid, 1'b0);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) step();
        v0 = 1'b1; d0 = 8'h55;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (acc0) v0 = 1'b0;
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            if (acc0) begin
                v0 = 1'($urandom % 2); d0 = 8'($urandom);
            end else if (!v0) begin
                if ($urandom % 4 == 0) begin v0 = 1'b1; d0 = 8'($urandom); end
            end else if ($urandom % 16 == 0) v0 = 1'b0;
            if (acc1) begin
                v1 = 1'($urandom % 2); d1 = 8'($urandom);
            end else if (!v1) begin
                if ($urandom % 4 == 0) begin v1 = 1'b1; d1 = 8'($urandom); end
            end else if ($urandom % 16 == 0) v1 = 1'b0;
        end
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
